viterbi_decoder_param: RTL



---
 rtl/viterbi_decoder_param.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_decoder_param.sv
// Rate-1/2 Viterbi decoder with generic constraint length, generators and soft width.
// Register-exchange survivors, one symbol per clock, sliding-window output plus end-of-frame flush.
module viterbi_decoder_param #(
    parameter int          K  = 7,
    parameter int unsigned G0 = 32'o133,
    parameter int unsigned G1 = 32'o171,
    parameter int          SW = 3,
    parameter int          D  = 36,
    parameter int          MW = 10
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          sym_valid,
    output logic          sym_ready,
    input  logic [SW-1:0] sym_a,
    input  logic [SW-1:0] sym_b,
    input  logic          sym_sof,
    input  logic          flush,
    output logic          out_bit,
    output logic          out_valid,
    output logic          done
);
    localparam int N  = 1 << (K - 1);
    localparam int NW = K - 1;
    localparam int FW = $clog2(D + 1);
    localparam int CW = $clog2(D);
    localparam logic [K-1:0]  G0_L    = K'(G0);
    localparam logic [K-1:0]  G1_L    = K'(G1);
    localparam logic [SW-1:0] SMAX    = {SW{1'b1}};
    localparam logic [MW-1:0] PM_INIT = {2'b01, {(MW-2){1'b0}}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [MW-1:0] init_pm_f(input int idx);
        return (idx == 0) ? {MW{1'b0}} : PM_INIT;
    endfunction

    function automatic logic [SW:0] bm_f(input logic ea, input logic eb,
                                         input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] da;
        logic [SW-1:0] db;
        da = ea ? (SMAX - a) : a;
        db = eb ? (SMAX - b) : b;
        return {1'b0, da} + {1'b0, db};
    endfunction

    state_t        state_q, state_d;
    logic [MW-1:0] pm_q   [N];
    logic [MW-1:0] pm_d   [N];
    logic [D-1:0]  path_q [N];
    logic [D-1:0]  path_d [N];
    logic [FW-1:0] fill_q, fill_d;
    logic [NW-1:0] best_f_q, best_f_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;
    logic          out_bit_q, out_bit_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
    logic          sym_ready_q, sym_ready_d;

    logic          acc_s;
    logic          init_base_s;
    logic          all_msb_s;
    logic [NW-1:0] best_s;
    logic [MW-1:0] base_s     [N];
    logic [MW-1:0] acs_pm_s   [N];
    logic [MW-1:0] pm_new_s   [N];
    logic [D-1:0]  acs_path_s [N];

    assign acc_s       = sym_valid && sym_ready_q;
    // A frame start, or the first symbol taken while in DONE, begins from the initial metrics.
    assign init_base_s = sym_sof || (state_q == ST_DONE);

    // Predecessor metric source: stored metrics or the frame-start values
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (init_base_s) begin
                base_s[i] = init_pm_f(i);
            end else begin
                base_s[i] = pm_q[i];
            end
        end
    end

    for (genvar s = 0; s < N; s++) begin : g_acs
        localparam int P0 = (2 * s) % N;
        localparam int P1 = (2 * s + 1) % N;
        localparam logic [K-1:0] R0 = K'(2 * s);
        localparam logic [K-1:0] R1 = K'(2 * s + 1);
        logic [SW:0]   bm0_s, bm1_s;
        logic [MW-1:0] c0_s, c1_s;
        logic          sel_s;
        assign bm0_s = bm_f(^(R0 & G0_L), ^(R0 & G1_L), sym_a, sym_b);
        assign bm1_s = bm_f(^(R1 & G0_L), ^(R1 & G1_L), sym_a, sym_b);
        assign c0_s  = base_s[P0] + MW'(bm0_s);
        assign c1_s  = base_s[P1] + MW'(bm1_s);
        assign sel_s = !(c0_s < c1_s);
        assign acs_pm_s[s]   = sel_s ? c1_s : c0_s;
        assign acs_path_s[s] = {(sel_s ? path_q[P1][D-2:0] : path_q[P0][D-2:0]), R0[K-1]};
    end

    // Renormalisation: drop the shared MSB once every survivor metric carries it
    always_comb begin
        all_msb_s = 1'b1;
        for (int i = 0; i < N; i++) begin
            all_msb_s = all_msb_s & acs_pm_s[i][MW-1];
        end
        for (int i = 0; i < N; i++) begin
            if (all_msb_s) begin
                pm_new_s[i] = {1'b0, acs_pm_s[i][MW-2:0]};
            end else begin
                pm_new_s[i] = acs_pm_s[i];
            end
        end
    end

    // Best state over the registered metrics, lowest index wins ties
    always_comb begin
        best_s = {NW{1'b0}};
        for (int i = 1; i < N; i++) begin
            if (pm_q[i] < pm_q[best_s]) begin
                best_s = NW'(i);
            end else begin
                best_s = best_s;
            end
        end
    end

    // Next-state logic: ACS commit, fill tracking, output selection and RUN/FLUSH/DONE sequencing
    always_comb begin
        state_d     = state_q;
        pm_d        = pm_q;
        path_d      = path_q;
        fill_d      = fill_q;
        best_f_d    = best_f_q;
        cnt_d       = cnt_q;
        acc_d       = acc_s;
        out_bit_d   = out_bit_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        sym_ready_d = sym_ready_q;
        if (acc_s) begin
            pm_d   = pm_new_s;
            path_d = acs_path_s;
            if (init_base_s) begin
                fill_d = FW'(1);
            end else if (fill_q != FW'(D)) begin
                fill_d = fill_q + FW'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            fill_d = fill_q;
        end
        case (state_q)
            ST_RUN: begin
                if (acc_q) begin
                    out_bit_d   = path_q[best_s][D-1];
                    out_valid_d = (fill_q == FW'(D));
                end else begin
                    out_bit_d = out_bit_q;
                end
                if (flush) begin
                    best_f_d = best_s;
                    if (fill_d >= FW'(2)) begin
                        state_d     = ST_FLUSH;
                        sym_ready_d = 1'b0;
                        cnt_d       = (fill_d == FW'(D)) ? CW'(D - 1) : CW'(fill_d - FW'(1));
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // A symbol taken on the flush edge still owes its sliding-window bit first.
                if (acc_q) begin
                    out_bit_d   = path_q[best_s][D-1];
                    out_valid_d = (fill_q == FW'(D));
                    best_f_d    = best_s;
                end else begin
                    out_bit_d   = path_q[best_f_q][cnt_q - CW'(1)];
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        sym_ready_d = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_DONE: begin
                state_d     = ST_RUN;
                sym_ready_d = 1'b1;
                if (!acc_s) begin
                    fill_d = {FW{1'b0}};
                    for (int i = 0; i < N; i++) begin
                        pm_d[i] = init_pm_f(i);
                    end
                end else begin
                    fill_d = FW'(1);
                end
            end
            default: begin
                state_d     = ST_RUN;
                sym_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                pm_q[i]   <= init_pm_f(i);
                path_q[i] <= {D{1'b0}};
            end
            state_q     <= ST_RUN;
            fill_q      <= {FW{1'b0}};
            best_f_q    <= {NW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            acc_q       <= 1'b0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            sym_ready_q <= 1'b1;
        end else begin
            pm_q        <= pm_d;
            path_q      <= path_d;
            state_q     <= state_d;
            fill_q      <= fill_d;
            best_f_q    <= best_f_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            sym_ready_q <= sym_ready_d;
        end
    end

    assign sym_ready = sym_ready_q;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule
